univ_reg: RTL and testbench

UNIV_REG -- requirements
Module: univ_reg

---
 rtl/univ_reg.sv | 120 ++++++++++++
 tb/tb_univ_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/univ_reg.sv
// Universal shift/rotate/count register with a multi-step sequencer.
// A start latches op and shamt, then repeats that op shamt times and pulses done.
module univ_reg #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [CNTW-1:0]  shamt,
  input  logic             sin,
  input  logic [WIDTH-1:0] PI,
  output logic [WIDTH-1:0] PO,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHL  = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_ROL  = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_INC  = 3'b101;
  localparam logic [2:0] OP_DEC  = 3'b110;
  localparam logic [2:0] OP_INV  = 3'b111;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             carry_q, carry_d;
  logic [2:0]       op_q, op_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_po;
  logic             step_c;

  // Single-step datapath; the sequencer reuses it with the latched op.
  always_comb begin
    step_op = (state_q == RUN) ? op_q : op;
    step_po = po_q;
    step_c  = carry_q;
    case (step_op)
      OP_SHL: begin step_po = {po_q[WIDTH-2:0], sin};         step_c = po_q[WIDTH-1]; end
      OP_SHR: begin step_po = {sin, po_q[WIDTH-1:1]};         step_c = po_q[0];       end
      OP_ROL: begin step_po = {po_q[WIDTH-2:0], po_q[WIDTH-1]}; step_c = po_q[WIDTH-1]; end
      OP_ROR: begin step_po = {po_q[0], po_q[WIDTH-1:1]};     step_c = po_q[0];       end
      OP_INC: begin step_po = po_q + 1'b1;                    step_c = &po_q;         end
      OP_DEC: begin step_po = po_q - 1'b1;                    step_c = ~|po_q;        end
      OP_INV: begin step_po = ~po_q;                                                  end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    po_d    = po_q;
    carry_d = carry_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      po_d    = '0;
      carry_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld) begin
            po_d    = PI;
            carry_d = 1'b0;
          end else if (start && op != OP_HOLD) begin
            op_d    = op;
            cnt_d   = shamt;
            state_d = (shamt != '0) ? RUN : DONE;
          end else begin
            po_d    = step_po;
            carry_d = step_c;
          end
        end
        RUN: begin
          po_d    = step_po;
          carry_d = step_c;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == {{(CNTW-1){1'b0}}, 1'b1}) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      po_q    <= '0;
      carry_q <= 1'b0;
      op_q    <= OP_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      po_q    <= po_d;
      carry_q <= carry_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PO    = po_q;
  assign carry = carry_q;
  assign zero  = (po_q == '0);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_univ_reg.sv
// Scoreboard bench for univ_reg: driver pushes model predictions per edge,
// an independent monitor pops and compares on the falling edge.
module tb_univ_reg;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst, clr, ld, start, sin;
  logic [2:0]       op;
  logic [CNTW-1:0]  shamt;
  logic [WIDTH-1:0] PI, PO;
  logic             carry, zero, busy, done;

  univ_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .op(op), .start(start),
    .shamt(shamt), .sin(sin), .PI(PI), .PO(PO), .carry(carry),
    .zero(zero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] po;
    logic             c, z, b, d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: pending step count plus a done flag, arithmetic on ints.
  int m_po = 0, m_c = 0, m_left = 0, m_done = 0, m_op = 0;

  task automatic apply_op(input int o, input int s);
    case (o)
      1: begin m_c = (m_po >> (WIDTH-1)) & 1; m_po = ((m_po << 1) | s) & MASK; end
      2: begin m_c = m_po & 1; m_po = (m_po >> 1) | (s << (WIDTH-1)); end
      3: begin m_c = (m_po >> (WIDTH-1)) & 1; m_po = ((m_po << 1) | m_c) & MASK; end
      4: begin m_c = m_po & 1; m_po = (m_po >> 1) | (m_c << (WIDTH-1)); end
      5: begin m_c = (m_po == MASK) ? 1 : 0; m_po = (m_po + 1) & MASK; end
      6: begin m_c = (m_po == 0) ? 1 : 0; m_po = (m_po + MASK) & MASK; end
      7: m_po = (~m_po) & MASK;
      default: ;
    endcase
  endtask

  task automatic model_edge();
    exp_t e;
    if (rst) begin
      m_po = 0; m_c = 0; m_left = 0; m_done = 0; m_op = 0;
    end else if (clr) begin
      m_po = 0; m_c = 0; m_left = 0; m_done = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_left > 0) begin
      apply_op(m_op, int'(sin));
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (ld) begin
      m_po = int'(PI); m_c = 0;
    end else if (start && op != 3'd0) begin
      m_op = int'(op); m_left = int'(shamt);
      if (m_left == 0) m_done = 1;
    end else begin
      apply_op(int'(op), int'(sin));
    end
    e.po = m_po[WIDTH-1:0];
    e.c  = m_c[0];
    e.z  = (m_po == 0);
    e.b  = (m_left > 0);
    e.d  = (m_done != 0);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic c, input logic l, input logic s,
                     input logic [2:0] o, input logic [CNTW-1:0] sh,
                     input logic si, input logic [WIDTH-1:0] p);
    rst = r; clr = c; ld = l; start = s; op = o; shamt = sh; sin = si; PI = p;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 3'd0, '0, 0, '0);
  endtask

  // Monitor: every pushed expectation is checked half a cycle after its edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (PO !== e.po || carry !== e.c || zero !== e.z || busy !== e.b || done !== e.d) begin
          n_fail++;
          $display("FAIL outputs @%0t: got PO=%h c=%b z=%b busy=%b done=%b, want PO=%h c=%b z=%b busy=%b done=%b",
                   $time, PO, carry, zero, busy, done, e.po, e.c, e.z, e.b, e.d);
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 3'd0, '0, 0, '0);
    cyc(1, 1, 1, 1, 3'd5, 4'd3, 1, 8'hAA);  // reset overrides everything
    idle_n(1);
    // Load then inc wrap
    cyc(0, 0, 1, 0, 3'd0, '0, 0, 8'hFF);
    cyc(0, 0, 0, 0, 3'd5, '0, 0, '0);
    idle_n(1);
    // Dec borrow after reset
    cyc(1, 0, 0, 0, 3'd0, '0, 0, '0);
    cyc(0, 0, 0, 0, 3'd6, '0, 0, '0);
    // rol sequence of 3 on 0x81
    cyc(0, 0, 1, 0, 3'd0, '0, 0, 8'h81);
    cyc(0, 0, 0, 1, 3'd3, 4'd3, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 3'd7, 4'd9, 1, 8'h55);  // ignored in RUN/DONE; ld lands after
    // Zero-length sequence
    cyc(0, 0, 1, 0, 3'd0, '0, 0, 8'h3C);
    cyc(0, 0, 0, 1, 3'd1, 4'd0, 1, '0);
    idle_n(2);
    // start with op=hold is ignored
    cyc(0, 0, 0, 1, 3'd0, 4'd4, 0, '0);
    idle_n(1);
    // Abort by clr, then by rst
    cyc(0, 0, 1, 0, 3'd0, '0, 0, 8'hB7);
    cyc(0, 0, 0, 1, 3'd2, 4'd5, 0, '0);
    cyc(0, 0, 0, 0, 3'd0, '0, 1, '0);
    cyc(0, 0, 0, 0, 3'd0, '0, 0, '0);
    cyc(0, 1, 0, 0, 3'd0, '0, 0, '0);
    idle_n(2);
    cyc(0, 0, 1, 0, 3'd0, '0, 0, 8'hB7);
    cyc(0, 0, 0, 1, 3'd2, 4'd5, 0, '0);
    cyc(0, 0, 0, 0, 3'd0, '0, 1, '0);
    cyc(0, 0, 0, 0, 3'd0, '0, 0, '0);
    cyc(1, 0, 0, 0, 3'd0, '0, 0, '0);
    idle_n(2);
    // Priority
    cyc(0, 0, 1, 0, 3'd0, '0, 0, 8'h42);
    cyc(0, 1, 1, 1, 3'd1, 4'd2, 0, 8'h99);
    idle_n(1);
    cyc(0, 0, 1, 1, 3'd1, 4'd2, 0, 8'h99);
    idle_n(1);
    // Maximum count, no wrap
    cyc(0, 0, 0, 1, 3'd5, 4'd15, 0, '0);
    idle_n(18);
    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 99) < 1),
          ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 10),
          ($urandom_range(0, 99) < 20),
          3'($urandom_range(0, 7)),
          CNTW'($urandom_range(0, (1 << CNTW) - 1)),
          1'($urandom_range(0, 1)),
          WIDTH'($urandom_range(0, MASK)));
    end
    idle_n(2);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
